// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl_pkg
// Description : Shared types and default constants for the CPU run/halt/step
//               clock controller (FSM state encoding, default debounce length,
//               default clock divider ratio).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } run_state_t;

    // Default debounce stability window in clk cycles
    localparam int c_DB_CYCLES_DEFAULT = 1_000_000;

    // Board-level power-up value for div_ratio
    localparam int c_DIV_RATIO_RESET = 10;

endpackage : cpu_run_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: 2-FF synchronizer, optional
//               debounce, rising-edge detector. Emits a one-clk pulse per
//               accepted press.
//               Macro CPU_RUN_CTRL_DEBOUNCE_EN: when defined, a level must
//               remain stable for DB_CYCLES clk cycles before it is accepted;
//               when undefined, the debounce stage is bypassed (press latency
//               is 3 clk cycles) and DB_CYCLES has no effect.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               btn_raw - raw asynchronous button level
//               press_p - one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_p
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_q;
    logic r_press;
    logic w_level;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
    localparam int c_DB_W    = $clog2(DB_CYCLES + 1);
    localparam int c_DB_LAST = (DB_CYCLES < 1) ? 0 : DB_CYCLES - 1;

    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_stable;

    // The accepted level only changes once the synchronized input has
    // differed from it for DB_CYCLES consecutive cycles; any bounce back
    // restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_W'(c_DB_LAST)) begin
            r_db_cnt <= '0;
            r_stable <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
    end

    assign w_level = r_stable;
`else
    // Without the debounce stage the window length plays no role.
    logic w_db_unused;
    assign w_db_unused = (DB_CYCLES != 0);

    assign w_level = r_sync2;
`endif

    // Rising-edge detector with registered pulse output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_q <= w_level;
            r_press   <= w_level & ~r_level_q;
        end
    end

    assign press_p = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run/halt/single-step controller for the CPU clock. Derives a
//               registered cpu_clk from clk at a programmable half-period,
//               supports halt/resume (btn_run), single-cycle stepping
//               (btn_step) and a core-side halt request, and counts cpu_clk
//               rising edges.
//               Macro CPU_RUN_CTRL_DEBOUNCE_EN enables full button debounce
//               in both btn_debounce instances.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               btn_run     - raw run/halt toggle button
//               btn_step    - raw single-step button
//               halt_req    - clk-synchronous halt request level
//               div_ratio   - cpu_clk half-period in clk cycles (0 acts as 1)
//               cpu_clk     - registered CPU clock
//               running     - high in RUN and DRAIN
//               cycle_count - cpu_clk rising edges since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV_W     = 32,
    parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT,
    parameter int START_RUN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             halt_req,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             cpu_clk,
    output logic             running,
    output logic [31:0]      cycle_count
);

    localparam run_state_t c_RESET_STATE = (START_RUN != 0) ? RUN : HALT;
    localparam logic       c_RESET_RUN   = (START_RUN != 0);

    logic             w_run_p;
    logic             w_step_p;
    logic [DIV_W-1:0] w_div_last;
    logic             w_tick;
    logic [DIV_W-1:0] w_cnt_next;

    run_state_t       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic             r_cpu_clk;
    logic             r_running;
    logic [31:0]      r_cycle_count;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_run),
        .press_p (w_run_p)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_step),
        .press_p (w_step_p)
    );

    // A ratio of 0 behaves as 1. The compare uses >= so that lowering
    // div_ratio below the current count ends the half-period at once instead
    // of letting the counter run all the way round.
    assign w_div_last = (div_ratio == '0) ? '0 : div_ratio - DIV_W'(1);
    assign w_tick     = (r_cnt >= w_div_last);
    assign w_cnt_next = w_tick ? '0 : r_cnt + DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_RESET_STATE;
            r_cnt         <= '0;
            r_cpu_clk     <= 1'b0;
            r_running     <= c_RESET_RUN;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                HALT: begin
                    r_cnt     <= '0;
                    r_cpu_clk <= 1'b0;
                    if (w_run_p) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end else if (w_step_p) begin
                        r_state   <= STEP;
                        r_running <= 1'b0;
                    end
                end

                RUN: begin
                    r_cnt <= w_cnt_next;
                    if (w_tick) begin
                        r_cpu_clk <= ~r_cpu_clk;
                        if (!r_cpu_clk) begin
                            r_cycle_count <= r_cycle_count + 32'd1;
                        end
                    end
                    // DRAIN still counts as running; the output drops with HALT
                    if (w_run_p || halt_req) begin
                        r_state <= DRAIN;
                    end
                end

                STEP: begin
                    r_cnt <= w_cnt_next;
                    if (w_tick) begin
                        r_cpu_clk <= ~r_cpu_clk;
                        if (!r_cpu_clk) begin
                            r_cycle_count <= r_cycle_count + 32'd1;
                        end else begin
                            // Falling edge completes the single cycle
                            r_state <= HALT;
                        end
                    end
                end

                DRAIN: begin
                    // Let a high phase run to its natural end so the core
                    // never sees a truncated clock pulse.
                    if (!r_cpu_clk) begin
                        r_cnt     <= '0;
                        r_state   <= HALT;
                        r_running <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_tick) begin
                            r_cpu_clk <= 1'b0;
                            r_state   <= HALT;
                            r_running <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state   <= HALT;
                    r_running <= 1'b0;
                    r_cnt     <= '0;
                    r_cpu_clk <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_clk     = r_cpu_clk;
    assign running     = r_running;
    assign cycle_count = r_cycle_count;

endmodule : cpu_run_ctrl
`default_nettype wire
